bnn_infer_ctrl: RTL and testbench

//  Sequencer placed in front of the combinational BNN datapath and its parameter ROM.
//  - Loads a ROWS x COLS binary image one row per valid/ready beat.
//  - Holds the image stable while the BNN settles, as a multicycle path.
//  - Registers the per-class scores and computes their argmax sequentially.
//  - Returns class index and max score over a valid/ready result port.

---
 rtl/bnn_infer_ctrl_if.sv | 46 ++++
 rtl/bnn_infer_ctrl.sv | 142 ++++++++++++++
 tb/tb_bnn_infer_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bnn_infer_ctrl_if.sv
// Bundle of the row-load, BNN and result signals of bnn_infer_ctrl.
//
// Handshake rule for both the row port and the result port:
//   A beat transfers on a rising clk edge where valid && ready. The producer
//   raises valid without waiting for ready. Once valid is up, the producer
//   holds it and its data stable until that transfer edge. The consumer can
//   drive ready freely, and can hold it high before valid arrives.
//
// dbg_state and dbg_rowcnt mirror the controller FSM state and row counter.
// They let checkers observe sequencing without probing inside the block.
interface bnn_infer_ctrl_if #(
  parameter int ROWS    = 28,
  parameter int COLS    = 28,
  parameter int NCLASS  = 10,
  parameter int SCORE_W = 7,
  parameter int CLS_W   = 4
);
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic                        row_valid_i;
  logic                        row_ready_o;
  logic [COLS-1:0]             row_data_i;
  logic [ROWS*COLS-1:0]        image_o;
  logic [NCLASS*SCORE_W-1:0]   scores_i;
  logic                        res_valid_o;
  logic                        res_ready_i;
  logic [CLS_W-1:0]            class_o;
  logic [SCORE_W-1:0]          max_score_o;
  logic                        busy_o;
  logic [2:0]                  dbg_state;
  logic [ROW_W-1:0]            dbg_rowcnt;

  // Controller side
  modport slave (
    input  row_valid_i, row_data_i, scores_i, res_ready_i,
    output row_ready_o, image_o, res_valid_o, class_o, max_score_o, busy_o,
           dbg_state, dbg_rowcnt
  );

  // Row source / result consumer / BNN side
  modport master (
    output row_valid_i, row_data_i, scores_i, res_ready_i,
    input  row_ready_o, image_o, res_valid_o, class_o, max_score_o, busy_o,
           dbg_state, dbg_rowcnt
  );
endinterface

// File: rtl/bnn_infer_ctrl.sv
// Sequencer in front of a combinational BNN datapath.
// The controller loads an image one row per beat, then holds the image for
// SETTLE_CYCLES so the BNN can settle as a multicycle path. It then captures
// the class scores and scans them for the argmax, one class per cycle. It
// returns the winning class and its score on the result port.
module bnn_infer_ctrl #(
  parameter int ROWS          = 28,
  parameter int COLS          = 28,
  parameter int NCLASS        = 10,
  parameter int SCORE_W       = 7,
  parameter int SETTLE_CYCLES = 8,
  parameter int CLS_W         = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  bnn_infer_ctrl_if.slave   bus
);

  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_LOAD    = 3'd0,
    S_SETTLE  = 3'd1,
    S_CAPTURE = 3'd2,
    S_ARGMAX  = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t                state_q;
  logic [ROW_W-1:0]      rowcnt_q;
  logic [SET_W-1:0]      settle_q;
  logic [CLS_W-1:0]      k_q;
  logic [SCORE_W-1:0]    best_q;
  logic [CLS_W-1:0]      best_idx_q;
  logic [ROWS*COLS-1:0]  image_q;
  logic [SCORE_W-1:0]    score_q [NCLASS];
  logic [CLS_W-1:0]      class_q;
  logic [SCORE_W-1:0]    max_q;
  logic                  res_valid_q;
  logic                  busy_q;

  logic [SCORE_W-1:0]    cur_score;
  logic                  take;
  logic [SCORE_W-1:0]    next_best;
  logic [CLS_W-1:0]      next_idx;

  // Compare step of the argmax scan. The comparison is strict, so on a tie
  // the earlier (lower) index keeps the lead.
  always_comb begin
    cur_score = score_q[k_q];
    take      = (cur_score > best_q);
    next_best = take ? cur_score : best_q;
    next_idx  = take ? k_q : best_idx_q;
  end

  // Controller FSM. This block holds all state and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_LOAD;
      rowcnt_q    <= '0;
      settle_q    <= '0;
      k_q         <= '0;
      best_q      <= '0;
      best_idx_q  <= '0;
      image_q     <= '0;
      class_q     <= '0;
      max_q       <= '0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      for (int i = 0; i < NCLASS; i++) score_q[i] <= '0;
    end else begin
      case (state_q)
        S_LOAD: begin
          // The previous image stays in place and is overwritten row by row.
          if (bus.row_valid_i) begin
            image_q[rowcnt_q*COLS +: COLS] <= bus.row_data_i;
            if (rowcnt_q == ROW_W'(ROWS - 1)) begin
              rowcnt_q <= '0;
              settle_q <= '0;
              busy_q   <= 1'b1;
              state_q  <= S_SETTLE;
            end else begin
              rowcnt_q <= rowcnt_q + 1'b1;
            end
          end
        end
        S_SETTLE: begin
          // The image is frozen. Wait out the BNN combinational delay.
          if (settle_q == SET_W'(SETTLE_CYCLES - 1)) begin
            state_q <= S_CAPTURE;
          end else begin
            settle_q <= settle_q + 1'b1;
          end
        end
        S_CAPTURE: begin
          for (int i = 0; i < NCLASS; i++) begin
            score_q[i] <= bus.scores_i[i*SCORE_W +: SCORE_W];
          end
          best_q     <= bus.scores_i[0 +: SCORE_W];
          best_idx_q <= '0;
          k_q        <= CLS_W'(1);
          state_q    <= S_ARGMAX;
        end
        S_ARGMAX: begin
          best_q     <= next_best;
          best_idx_q <= next_idx;
          if (k_q == CLS_W'(NCLASS - 1)) begin
            class_q     <= next_idx;
            max_q       <= next_best;
            res_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        S_DONE: begin
          // The result and image stay put until the consumer accepts.
          if (bus.res_ready_i) begin
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= S_LOAD;
          end
        end
        default: begin
          state_q <= S_LOAD;
        end
      endcase
    end
  end

  // While reset is held, gate ready so no beat is advertised.
  assign bus.row_ready_o = (state_q == S_LOAD) && !rst_i;
  assign bus.image_o     = image_q;
  assign bus.res_valid_o = res_valid_q;
  assign bus.class_o     = class_q;
  assign bus.max_score_o = max_q;
  assign bus.busy_o      = busy_q;
  assign bus.dbg_state   = state_q;
  assign bus.dbg_rowcnt  = rowcnt_q;

endmodule

// File: tb/tb_bnn_infer_ctrl.sv
// Directed bench for bnn_infer_ctrl. The BNN scores are driven by a stub.
// Each expected result is queued before its image load starts.
module tb_bnn_infer_ctrl;

  localparam int ROWS    = 28;
  localparam int COLS    = 28;
  localparam int NCLASS  = 10;
  localparam int SCORE_W = 7;
  localparam int CLS_W   = 4;
  localparam int SETTLE  = 8;
  localparam int IMG_W   = ROWS * COLS;
  localparam int LAT     = SETTLE + NCLASS;

  localparam logic [2:0] ST_LOAD   = 3'd0;
  localparam logic [2:0] ST_SETTLE = 3'd1;
  localparam logic [2:0] ST_DONE   = 3'd4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bnn_infer_ctrl_if #(
    .ROWS(ROWS), .COLS(COLS), .NCLASS(NCLASS), .SCORE_W(SCORE_W), .CLS_W(CLS_W)
  ) bus ();

  bnn_infer_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .NCLASS(NCLASS), .SCORE_W(SCORE_W),
    .SETTLE_CYCLES(SETTLE), .CLS_W(CLS_W)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [CLS_W+SCORE_W-1:0] exp_q[$];
  logic [IMG_W-1:0]         diag_img;

  task automatic check(input string tag, input logic [IMG_W-1:0] got,
                       input logic [IMG_W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic [SCORE_W-1:0] v);
    for (int k = 0; k < NCLASS; k++) bus.scores_i[k*SCORE_W +: SCORE_W] = v;
  endtask

  task automatic set_one(input int k, input logic [SCORE_W-1:0] v);
    bus.scores_i[k*SCORE_W +: SCORE_W] = v;
  endtask

  // Row r = 1 << r. With gaps, valid drops for 3 cycles before rows 6 and 27.
  // The routine returns just after the final beat edge (E0).
  task automatic load_image(input bit gaps);
    logic [COLS-1:0] one;
    one = 1;
    for (int r = 0; r < ROWS; r++) begin
      if (gaps && (r == 6 || r == 27)) begin
        bus.row_valid_i = 1'b0;
        repeat (3) tick();
      end
      bus.row_valid_i = 1'b1;
      bus.row_data_i  = one << r;
      tick();
    end
    bus.row_valid_i = 1'b0;
    bus.row_data_i  = '0;
  endtask

  // Count the edges until res_valid_o is high. The count is capped at 100.
  task automatic wait_result(output int n);
    n = 0;
    while (bus.res_valid_o !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic check_result(input string tag);
    logic [CLS_W+SCORE_W-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_class"}, bus.class_o, e[SCORE_W +: CLS_W]);
      check({tag, "_score"}, bus.max_score_o, e[0 +: SCORE_W]);
    end
  endtask

  task automatic accept(input string tag);
    bus.res_ready_i = 1'b1;
    tick();
    bus.res_ready_i = 1'b0;
    check({tag, "_valid_drop"}, bus.res_valid_o, 0);
    check({tag, "_ready_back"}, bus.row_ready_o, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int seen;

    diag_img = '0;
    for (int r = 0; r < ROWS; r++) diag_img[r*COLS + r] = 1'b1;

    rst             = 1'b1;
    bus.row_valid_i = 1'b0;
    bus.row_data_i  = '0;
    bus.res_ready_i = 1'b0;
    set_all(0);
    repeat (3) tick();
    check("ready_in_reset", bus.row_ready_o, 0);
    rst = 1'b0;
    #1;
    check("rst_row_ready", bus.row_ready_o, 1);
    check("rst_res_valid", bus.res_valid_o, 0);
    check("rst_busy", bus.busy_o, 0);
    check("rst_image", bus.image_o, 0);
    check("rst_class", bus.class_o, 0);
    check("rst_max", bus.max_score_o, 0);
    check("rst_state", bus.dbg_state, ST_LOAD);

    // A: class 9 scores 127, all others score 3. Rows are back to back.
    set_all(3);
    set_one(9, 127);
    exp_q.push_back({4'd9, 7'd127});
    load_image(0);
    check("a_busy_rise", bus.busy_o, 1);
    check("a_state_settle", bus.dbg_state, ST_SETTLE);
    check("a_no_valid_yet", bus.res_valid_o, 0);
    check("a_image", bus.image_o, diag_img);
    wait_result(n);
    check("a_latency", n, LAT);
    check_result("a");
    // Hold the result. Row beats offered now must be ignored.
    bus.row_valid_i = 1'b1;
    bus.row_data_i  = '1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("a_hold_valid", bus.res_valid_o, 1);
      check("a_hold_class", bus.class_o, 9);
      check("a_hold_ready", bus.row_ready_o, 0);
    end
    bus.row_valid_i = 1'b0;
    bus.row_data_i  = '0;
    check("a_hold_image", bus.image_o, diag_img);
    check("a_hold_state", bus.dbg_state, ST_DONE);
    accept("a");
    check("a_rowcnt", bus.dbg_rowcnt, 0);
    check("a_busy_fall", bus.busy_o, 0);

    // B: all scores 5, so the tie goes to class 0. The rows have gaps and
    // the result consumer is ready before the result is valid.
    set_all(5);
    exp_q.push_back({4'd0, 7'd5});
    bus.res_ready_i = 1'b1;
    load_image(1);
    check("b_image", bus.image_o, diag_img);
    wait_result(n);
    check("b_latency", n, LAT);
    check_result("b");
    tick();
    check("b_one_cycle_valid", bus.res_valid_o, 0);
    check("b_ready_back", bus.row_ready_o, 1);
    bus.res_ready_i = 1'b0;

    // C: reset in settle cycle 4. No result may follow.
    set_all(9);
    load_image(0);
    repeat (4) tick();
    check("c_in_settle", bus.dbg_state, ST_SETTLE);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("c_state", bus.dbg_state, ST_LOAD);
    check("c_image", bus.image_o, 0);
    check("c_res_valid", bus.res_valid_o, 0);
    check("c_busy", bus.busy_o, 0);
    check("c_rowcnt", bus.dbg_rowcnt, 0);
    check("c_row_ready", bus.row_ready_o, 1);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.res_valid_o !== 1'b0) seen = 1;
    end
    check("c_no_result", seen, 0);

    // D: fresh load after reset with all-zero scores. Expect class 0, score 0.
    set_all(0);
    exp_q.push_back({4'd0, 7'd0});
    load_image(0);
    check("d_image", bus.image_o, diag_img);
    wait_result(n);
    check("d_latency", n, LAT);
    check_result("d");
    accept("d");

    // E: classes 3 and 7 tie at 100 and all others score 1. Expect class 3.
    set_all(1);
    set_one(3, 100);
    set_one(7, 100);
    exp_q.push_back({4'd3, 7'd100});
    load_image(0);
    wait_result(n);
    check("e_latency", n, LAT);
    check_result("e");
    accept("e");

    // F: the running maximum moves down the class list. Expect class 8.
    set_all(0);
    set_one(1, 10);
    set_one(4, 40);
    set_one(8, 90);
    set_one(9, 89);
    exp_q.push_back({4'd8, 7'd90});
    load_image(0);
    wait_result(n);
    check("f_latency", n, LAT);
    check_result("f");
    accept("f");

    check("sb_drained", exp_q.size(), 0);

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
